// File: rtl/spmv_seg_pkg.sv
// Shared types and default widths for the per-segment input-vector loader.
// The fallback macros keep the block buildable without the global config header.
`ifndef DATA_WIDTH_INPUT
`define DATA_WIDTH_INPUT 16
`endif
`ifndef BLK_SLOW_PARR_WR_NUM
`define BLK_SLOW_PARR_WR_NUM 4
`endif
`ifndef BITS_ADDR_SEG
`define BITS_ADDR_SEG 3
`endif
`ifndef NUM_INPUTs_PER_SEG_ARR
`define NUM_INPUTs_PER_SEG_ARR 8
`endif
`ifndef BITS_INPUT_BIN_ADDR
`define BITS_INPUT_BIN_ADDR 2
`endif

package spmv_seg_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StFill,
    StLast,
    StDone
  } seg_ld_state_t;

  localparam int unsigned ROW_CNT_W  = `BITS_ADDR_SEG + 1;
  localparam int unsigned LANE_CNT_W = `BITS_INPUT_BIN_ADDR;

endpackage

// File: rtl/segment_input_loader_lane_packer.sv
// Packs consecutive stream words into one row; the finished row is captured on
// commit so the next row can start filling while the write is in flight.
module lane_packer #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned PARR       = 4,
  parameter int unsigned LANE_W     = (PARR > 1) ? $clog2(PARR) : 1
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             in_fire,
  input  logic                             commit,
  input  logic [DATA_WIDTH-1:0]            in_data,
  output logic [LANE_W-1:0]                lane_cnt,
  output logic [PARR-1:0][DATA_WIDTH-1:0]  row_data
);

  logic [PARR-1:0][DATA_WIDTH-1:0] pack_q, merged;
  logic [PARR-1:0][DATA_WIDTH-1:0] row_q;
  logic [LANE_W-1:0]               lane_q;

  always_comb begin
    merged = pack_q;
    if (in_fire) begin
      merged[lane_q] = in_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pack_q <= '0;
      row_q  <= '0;
      lane_q <= '0;
    end else if (commit) begin
      // Unfilled lanes of a short last row stay zero because pack_q is cleared here.
      row_q  <= merged;
      pack_q <= '0;
      lane_q <= '0;
    end else if (in_fire) begin
      pack_q <= merged;
      lane_q <= lane_q + LANE_W'(1);
    end
  end

  assign lane_cnt = lane_q;
  assign row_data = row_q;

endmodule

// File: rtl/segment_input_loader.sv
// Write-side controller for the segment input memory: packs PARR stream words
// per row, issues one row write per row and tracks committed rows for the reader.
module segment_input_loader
  import spmv_seg_pkg::*;
#(
  parameter int unsigned DATA_WIDTH          = `DATA_WIDTH_INPUT,
  parameter int unsigned PARR                = `BLK_SLOW_PARR_WR_NUM,
  parameter int unsigned BITS_ADDR_SEG       = ROW_CNT_W - 1,
  parameter int unsigned NUM_ROWS            = `NUM_INPUTs_PER_SEG_ARR,
  parameter int unsigned BITS_ADDR_SEG_W_BIN = BITS_ADDR_SEG + LANE_CNT_W
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                seg_start,
  input  logic [BITS_ADDR_SEG_W_BIN:0]        seg_len,
  input  logic                                seg_release,
  input  logic                                in_valid,
  output logic                                in_ready,
  input  logic [DATA_WIDTH-1:0]               in_data,
  input  logic                                rd_en_adv,
  input  logic [BITS_ADDR_SEG-1:0]            adv_rd_addr_seg,
  output logic                                wr_en_adv,
  output logic [BITS_ADDR_SEG_W_BIN-1:0]      wr_addr_input_w_bin,
  output logic [PARR-1:0][DATA_WIDTH-1:0]     data_in_input,
  output logic                                adv_rd_wr_addr_match_flag,
  output logic                                rd_row_valid,
  output logic [BITS_ADDR_SEG:0]              rows_written,
  output logic                                seg_done
);

  localparam int unsigned LenW   = BITS_ADDR_SEG_W_BIN + 1;
  localparam int unsigned RowW   = BITS_ADDR_SEG + 1;
  localparam int unsigned BinW   = BITS_ADDR_SEG_W_BIN - BITS_ADDR_SEG;
  localparam int unsigned LaneW  = (PARR > 1) ? $clog2(PARR) : 1;
  localparam logic [LenW-1:0] MaxLen = LenW'(NUM_ROWS * PARR);

  seg_ld_state_t            state_q, state_d;
  logic [LenW-1:0]          len_q, len_d;
  logic [LenW-1:0]          word_cnt_q, word_cnt_d;
  logic [RowW-1:0]          rows_written_q, rows_written_d;
  logic [BITS_ADDR_SEG-1:0] wr_row_q, wr_row_d;
  logic                     wr_en_q, wr_en_d;

  logic [LenW-1:0]  clamped_len;
  logic [LaneW-1:0] lane_cnt;
  logic             in_fire, last_word, lane_full, commit;

  assign clamped_len = (seg_len > MaxLen) ? MaxLen : seg_len;
  assign in_ready    = (state_q == StFill);
  assign in_fire     = in_valid & in_ready;
  assign last_word   = (word_cnt_q == len_q - LenW'(1));
  assign lane_full   = (lane_cnt == LaneW'(PARR - 1));
  assign commit      = in_fire & (lane_full | last_word);

  lane_packer #(
    .DATA_WIDTH (DATA_WIDTH),
    .PARR       (PARR),
    .LANE_W     (LaneW)
  ) u_lane_packer (
    .clk      (clk),
    .rst      (rst),
    .in_fire  (in_fire),
    .commit   (commit),
    .in_data  (in_data),
    .lane_cnt (lane_cnt),
    .row_data (data_in_input)
  );

  always_comb begin
    state_d        = state_q;
    len_d          = len_q;
    word_cnt_d     = word_cnt_q;
    rows_written_d = rows_written_q;
    wr_row_d       = wr_row_q;
    wr_en_d        = commit;

    // The row of the committing word is the word index with the lane bits dropped.
    if (commit) begin
      wr_row_d = word_cnt_q[BinW +: BITS_ADDR_SEG];
    end
    if (wr_en_q) begin
      rows_written_d = rows_written_q + RowW'(1);
    end
    if (in_fire) begin
      word_cnt_d = word_cnt_q + LenW'(1);
    end

    unique case (state_q)
      StIdle: begin
        if (seg_start) begin
          len_d          = clamped_len;
          word_cnt_d     = '0;
          rows_written_d = '0;
          state_d        = (clamped_len != '0) ? StFill : StDone;
        end
      end
      StFill: begin
        if (in_fire && last_word) begin
          state_d = StLast;
        end
      end
      StLast: begin
        state_d = StDone;
      end
      StDone: begin
        if (seg_release) begin
          state_d        = StIdle;
          rows_written_d = '0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= StIdle;
      len_q          <= '0;
      word_cnt_q     <= '0;
      rows_written_q <= '0;
      wr_row_q       <= '0;
      wr_en_q        <= 1'b0;
    end else begin
      state_q        <= state_d;
      len_q          <= len_d;
      word_cnt_q     <= word_cnt_d;
      rows_written_q <= rows_written_d;
      wr_row_q       <= wr_row_d;
      wr_en_q        <= wr_en_d;
    end
  end

  assign wr_en_adv                 = wr_en_q;
  assign wr_addr_input_w_bin       = {wr_row_q, {BinW{1'b0}}};
  assign rows_written              = rows_written_q;
  assign seg_done                  = (state_q == StDone);
  assign adv_rd_wr_addr_match_flag = rd_en_adv & wr_en_q & (adv_rd_addr_seg == wr_row_q);
  assign rd_row_valid              = ({1'b0, adv_rd_addr_seg} < rows_written_q);

endmodule

// File: tb/tb_segment_input_loader.sv
// Self-checking bench for segment_input_loader with PARR=4, NUM_ROWS=8.
module tb_segment_input_loader;

  localparam int DW   = 16;
  localparam int PARR = 4;
  localparam int SW   = 3;
  localparam int AW   = 5;
  localparam int LW   = AW + 1;
  localparam int MAXW = 32;

  logic                      clk = 1'b0;
  logic                      rst;
  logic                      seg_start, seg_release, in_valid, in_ready, rd_en_adv;
  logic [LW-1:0]             seg_len;
  logic [DW-1:0]             in_data;
  logic [SW-1:0]             adv_rd_addr_seg;
  logic                      wr_en_adv, match_flag, rd_row_valid, seg_done;
  logic [AW-1:0]             wr_addr;
  logic [PARR-1:0][DW-1:0]   data_in_input;
  logic [SW:0]               rows_written;

  segment_input_loader #(
    .DATA_WIDTH          (DW),
    .PARR                (PARR),
    .BITS_ADDR_SEG       (SW),
    .NUM_ROWS            (8),
    .BITS_ADDR_SEG_W_BIN (AW)
  ) dut (
    .clk                       (clk),
    .rst                       (rst),
    .seg_start                 (seg_start),
    .seg_len                   (seg_len),
    .seg_release               (seg_release),
    .in_valid                  (in_valid),
    .in_ready                  (in_ready),
    .in_data                   (in_data),
    .rd_en_adv                 (rd_en_adv),
    .adv_rd_addr_seg           (adv_rd_addr_seg),
    .wr_en_adv                 (wr_en_adv),
    .wr_addr_input_w_bin       (wr_addr),
    .data_in_input             (data_in_input),
    .adv_rd_wr_addr_match_flag (match_flag),
    .rd_row_valid              (rd_row_valid),
    .rows_written              (rows_written),
    .seg_done                  (seg_done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [AW-1:0]      addr;
    logic [PARR*DW-1:0] data;
  } wr_t;

  typedef struct {
    int len;
    bit gaps;
    bit rnd;
    int exp_rows;
  } vec_t;

  wr_t wr_log[$];
  int  n_pass  = 0;
  int  n_total = 0;

  always @(negedge clk) begin
    if (!rst && wr_en_adv) wr_log.push_back('{addr: wr_addr, data: data_in_input});
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input longint unsigned act,
                       input longint unsigned exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Streams one segment, then compares every row write against the word->row/lane mapping.
  task automatic run_seg(input int len, input bit gaps, input bit rnd, input int exp_rows);
    logic [DW-1:0]      words[$];
    logic [PARR*DW-1:0] m;
    int n, idx, guard, eff;
    bit fire;
    wr_log.delete();
    seg_len = LW'(len);
    eff = int'(seg_len);
    n = (eff > MAXW) ? MAXW : eff;
    for (int i = 0; i < n; i++) words.push_back(rnd ? DW'($urandom) : DW'(i + 1));
    seg_start = 1'b1;
    tick();
    seg_start = 1'b0;
    if (n == 0) check("len0_done_next", seg_done, 1);
    idx = 0;
    guard = 0;
    while (idx < n && guard < 2000) begin
      in_valid = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
      in_data  = words[idx];
      fire     = in_valid && in_ready;
      tick();
      if (fire) idx++;
      guard++;
    end
    in_valid = 1'b0;
    if (guard >= 2000) check("stream_timeout", idx, n);
    guard = 0;
    while (!seg_done && guard < 10) begin
      tick();
      guard++;
    end
    check("seg_done", seg_done, 1);
    check("in_ready_after", in_ready, 0);
    check("wr_count", wr_log.size(), exp_rows);
    check("rows_written", rows_written, exp_rows);
    for (int r = 0; r < wr_log.size(); r++) begin
      for (int j = 0; j < PARR; j++) begin
        m[j*DW +: DW] = (r * PARR + j < n) ? words[r * PARR + j] : '0;
      end
      check($sformatf("wr_addr_%0d", r), wr_log[r].addr, r * PARR);
      check($sformatf("wr_data_%0d", r), wr_log[r].data, m);
    end
    seg_release = 1'b1;
    tick();
    seg_release = 1'b0;
    check("released", seg_done, 0);
  endtask

  vec_t vecs[7];

  initial begin
    vecs[0] = '{len: 8,   gaps: 1'b0, rnd: 1'b0, exp_rows: 2};
    vecs[1] = '{len: 6,   gaps: 1'b0, rnd: 1'b0, exp_rows: 2};
    vecs[2] = '{len: 32,  gaps: 1'b1, rnd: 1'b1, exp_rows: 8};
    vecs[3] = '{len: 0,   gaps: 1'b0, rnd: 1'b0, exp_rows: 0};
    vecs[4] = '{len: 100, gaps: 1'b0, rnd: 1'b1, exp_rows: 8};
    vecs[5] = '{len: 1,   gaps: 1'b0, rnd: 1'b1, exp_rows: 1};
    vecs[6] = '{len: 13,  gaps: 1'b1, rnd: 1'b1, exp_rows: 4};

    rst = 1'b1;
    seg_start = 0; seg_release = 0; in_valid = 0; rd_en_adv = 0;
    seg_len = '0; in_data = '0; adv_rd_addr_seg = '0;
    tick();
    tick();
    rst = 1'b0;
    tick();
    check("rst_in_ready", in_ready, 0);
    check("rst_wr_en", wr_en_adv, 0);
    check("rst_seg_done", seg_done, 0);
    check("rst_rows_written", rows_written, 0);
    check("rst_data", data_in_input, 0);

    // Back-to-back len=8 with exact timing, a stray seg_start and reader probes.
    wr_log.delete();
    seg_len = 8;
    seg_start = 1'b1;
    check("a_ready_idle", in_ready, 0);
    tick();
    for (int k = 1; k <= 8; k++) begin
      if (k == 1) check("a_ready_rise", in_ready, 1);
      if (k == 3) begin
        seg_start = 1'b1;
        seg_len = 2;
      end else begin
        seg_start = 1'b0;
      end
      in_valid = 1'b1;
      in_data = DW'(k);
      if (k == 5) begin
        check("a_row0_wr_en", wr_en_adv, 1);
        check("a_row0_addr", wr_addr, 0);
        check("a_row0_data", data_in_input, 64'h0004_0003_0002_0001);
      end
      if (k == 6) begin
        check("a_single_pulse", wr_en_adv, 0);
        check("a_rows_written_1", rows_written, 1);
      end
      if (k == 8) begin
        rd_en_adv = 1'b1;
        adv_rd_addr_seg = 1;
        #1;
        check("a_valid_early", rd_row_valid, 0);
      end
      tick();
    end
    in_valid = 1'b0;
    #1;
    check("a_match_flag", match_flag, 1);
    check("a_row1_addr", wr_addr, 4);
    check("a_row1_data", data_in_input, 64'h0008_0007_0006_0005);
    check("a_ready_fell", in_ready, 0);
    check("a_done_not_yet", seg_done, 0);
    tick();
    check("a_seg_done", seg_done, 1);
    check("a_rows_written_2", rows_written, 2);
    check("a_valid_t2", rd_row_valid, 1);
    check("a_match_gone", match_flag, 0);
    check("a_wr_count", wr_log.size(), 2);
    rd_en_adv = 1'b0;
    adv_rd_addr_seg = '0;
    seg_release = 1'b1;
    tick();
    seg_release = 1'b0;
    check("a_release_done", seg_done, 0);
    check("a_release_rows", rows_written, 0);

    // Asynchronous reset mid-segment after word 3.
    wr_log.delete();
    seg_len = 8;
    seg_start = 1'b1;
    tick();
    seg_start = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      in_valid = 1'b1;
      in_data = DW'(k + 40);
      tick();
    end
    in_valid = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    check("b_rst_ready", in_ready, 0);
    check("b_rst_wr_en", wr_en_adv, 0);
    check("b_rst_addr", wr_addr, 0);
    check("b_rst_data", data_in_input, 0);
    check("b_rst_rows", rows_written, 0);
    tick();
    tick();
    rst = 1'b0;
    tick();
    check("b_no_write", wr_log.size(), 0);
    run_seg(8, 1'b0, 1'b1, 2);

    for (int v = 0; v < 7; v++) begin
      run_seg(vecs[v].len, vecs[v].gaps, vecs[v].rnd, vecs[v].exp_rows);
    end

    for (int i = 0; i < 10; i++) begin
      int len, n;
      len = $urandom_range(0, 63);
      n = (len > MAXW) ? MAXW : len;
      run_seg(len, 1'b1, 1'b1, (n + PARR - 1) / PARR);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
